regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have one parameter: FAIR, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-003 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- wb0_valid  in  1  requester 0 (ALU) has a writeback.
- wb0_reg  in  5  requester 0 destination register.
- wb0_data  in  32  requester 0 write data.
- wb0_ready  out  1  requester 0 granted this cycle.
- wb1_valid  in  1  requester 1 (load) has a writeback.
- wb1_reg  in  5  requester 1 destination register.
- wb1_data  in  32  requester 1 write data.
- wb1_ready  out  1  requester 1 granted this cycle.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_reg  in  5  register being reserved.
- rsv_ready  out  1  reservation accepted this cycle.
- rs1, rs2  in  5 each  source registers to check for hazards.
- rs1_busy, rs2_busy  out  1 each  the named source holds a pending or in-flight value.
- reg_write  out  1  register-file write enable.
- write_reg  out  5  register-file write address.
- write_data  out  32  register-file write data.
- conflict_cnt  out  16  number of cycles in which both requesters were valid.

Function
REQ-004 Acceptance SHALL occur when wbN_valid && wbN_ready; at most one of wb0_ready and wb1_ready SHALL be high in any cycle.
REQ-005 wbN_ready SHALL be combinational and SHALL depend only on the valids and on last_grant; if only one requester is valid, that requester SHALL be granted.
REQ-006 When both requesters are valid and FAIR=1, the requester not granted last SHALL be granted; when FAIR=0, requester 0 SHALL always be granted.
REQ-007 last_grant SHALL update to the accepted requester's index on each acceptance and SHALL hold its value otherwise.
REQ-008 reg_write, write_reg and write_data SHALL be registered, giving one cycle of latency: an acceptance in cycle N drives the write in cycle N+1.
REQ-009 With no acceptance, reg_write SHALL be 0 in the next cycle, and write_reg and write_data SHALL hold their values.
REQ-010 An accepted write to register 0 SHALL be consumed, with reg_write=0 in the next cycle.
REQ-011 The block SHALL keep a 32-bit busy vector, and busy[0] SHALL be constant 0.
REQ-012 rsv_ready SHALL equal !busy[rsv_reg] || rsv_reg==0, using registered busy only.
REQ-013 On rsv_valid && rsv_ready && rsv_reg!=0, busy[rsv_reg] SHALL set at the clock edge.
REQ-014 On a writeback acceptance to R, busy[R] SHALL clear at the same clock edge.
REQ-015 If a reservation set and a writeback clear target the same R on the same edge, the set SHALL win.
REQ-016 A writeback to a register that is not busy SHALL be legal and SHALL leave busy unchanged.
REQ-017 rsK_busy SHALL be (busy[rsK] || (reg_write && write_reg==rsK)) && rsK!=0, so that the in-flight write cycle is covered.
REQ-018 conflict_cnt SHALL increment each cycle in which wb0_valid && wb1_valid, and SHALL saturate at 16'hFFFF.

Reset
REQ-019 On rst, at the clock edge, the block SHALL set busy=0, reg_write=0, write_reg=0, write_data=0, conflict_cnt=0 and last_grant=1, so that requester 0 wins the first conflict.
REQ-020 While rst is high, wb0_ready, wb1_ready and rsv_ready SHALL be 0.
REQ-021 An acceptance or reservation presented in a reset cycle SHALL be discarded.
REQ-022 A write in flight when reset is asserted SHALL be dropped: reg_write=0 in the following cycle.

Verification
REQ-023 Single requester: wb1_valid with reg 5 and data 0xDEADBEEF in cycle N -> wb1_ready=1 in N; reg_write=1, write_reg=5, write_data=0xDEADBEEF in N+1; reg_write=0 in N+2.
REQ-024 Round-robin: both requesters valid for 4 cycles after reset with FAIR=1 -> grants 0,1,0,1 and conflict_cnt=4; the same test with FAIR=0 -> grants 0,0,0,0.
REQ-025 Scoreboard: reserve reg 7 -> rs1=7 gives rs1_busy=1, and a second reserve of 7 gives rsv_ready=0.
- Then writeback of 7 accepted in cycle N -> rs1_busy=1 in N+1 (in flight) and 0 in N+2.
REQ-026 Simultaneous events: reserve of 9 and writeback of unreserved 9 on the same edge -> busy[9]=1 afterwards.
- Writeback of reg 0 accepted -> reg_write stays 0.
REQ-027 Reset mid-operation: busy[3]=1, write in flight and conflict_cnt=10, then rst for 1 cycle -> all outputs 0 and rs1=3 gives rs1_busy=0.
- Next conflict after reset -> grant to requester 0.
REQ-028 Saturation: preload by 65540 conflict cycles -> conflict_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Merges two writeback requesters (ALU on port 0, load unit on port 1) onto
// the single register-file write port. It also keeps a busy scoreboard, which
// the issue stage uses to reserve destinations and to detect source hazards.
//
// Parameters
//   FAIR          1 = round-robin between the two requesters,
//                 0 = requester 0 always wins a conflict
//
// Ports
//   clk           clock; every state update happens on the rising edge
//   rst           synchronous active-high reset
//   wb0_*         requester 0: valid / destination reg / data, ready = grant
//   wb1_*         requester 1: valid / destination reg / data, ready = grant
//   rsv_valid     issue stage wants to reserve rsv_reg
//   rsv_reg       register to reserve
//   rsv_ready     reservation accepted this cycle
//   rs1, rs2      source registers to test for hazards
//   rs1_busy      rs1 has a pending or in-flight value
//   rs2_busy      rs2 has a pending or in-flight value
//   reg_write     register-file write enable (registered)
//   write_reg     register-file write address (registered)
//   write_data    register-file write data (registered)
//   conflict_cnt  saturating count of cycles with both requesters valid
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wb0_valid,
    input  logic [4:0]  wb0_reg,
    input  logic [31:0] wb0_data,
    output logic        wb0_ready,

    input  logic        wb1_valid,
    input  logic [4:0]  wb1_reg,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,

    input  logic        rsv_valid,
    input  logic [4:0]  rsv_reg,
    output logic        rsv_ready,

    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,

    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,

    output logic [15:0] conflict_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Index of the requester accepted most recently. Reset value 1 makes
    // requester 0 the winner of the first conflict under round-robin.
    logic        last_grant;

    // One bit per architectural register: a value is still being produced.
    logic [31:0] busy;
    logic [31:0] busy_next;

    // Acceptance decode for the current cycle.
    logic        acc0;
    logic        acc1;
    logic        acc_any;
    logic [4:0]  acc_reg;
    logic [31:0] acc_data;
    logic        rsv_fire;
    logic        conflict;

    assign conflict = wb0_valid && wb1_valid;

    // -----------------------------------------------------------------------
    // Grant logic. Purely combinational on the valids and last_grant; the
    // reset gate keeps every handshake closed during a reset cycle so that
    // nothing presented then can be accepted.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of an always_comb gets a default on entry so no
        // path leaves it unassigned; a missing default infers a latch.
        wb0_ready = 1'b0;
        wb1_ready = 1'b0;
        if (!rst) begin
            if (conflict) begin
                // Round-robin hands the conflict to whoever did not win last.
                if ((FAIR != 0) && (last_grant == 1'b0)) begin
                    wb1_ready = 1'b1;
                end else begin
                    wb0_ready = 1'b1;
                end
            end else if (wb0_valid) begin
                wb0_ready = 1'b1;
            end else if (wb1_valid) begin
                wb1_ready = 1'b1;
            end
        end
    end

    assign acc0     = wb0_valid && wb0_ready;
    assign acc1     = wb1_valid && wb1_ready;
    assign acc_any  = acc0 || acc1;
    assign acc_reg  = acc1 ? wb1_reg  : wb0_reg;
    assign acc_data = acc1 ? wb1_data : wb0_data;

    // -----------------------------------------------------------------------
    // Reservation handshake. Only the registered scoreboard is consulted, so
    // a writeback in this same cycle cannot free the register early.
    // Register 0 is hardwired, so reserving it is always accepted and has no
    // effect.
    // -----------------------------------------------------------------------
    assign rsv_ready = !rst && (!busy[rsv_reg] || (rsv_reg == 5'd0));
    assign rsv_fire  = rsv_valid && rsv_ready && (rsv_reg != 5'd0);

    // -----------------------------------------------------------------------
    // Scoreboard next state. The clear is applied before the set so that a
    // reservation of the register being written back on the same edge wins:
    // the new producer owns the register after the edge. Clearing a register
    // that was never reserved is harmless.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_next = busy;
        if (acc_any) begin
            busy_next[acc_reg] = 1'b0;
        end
        if (rsv_fire) begin
            busy_next[rsv_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Hazard outputs. The in-flight term covers the cycle in which the busy
    // bit has already cleared but the register file has not yet been written.
    // -----------------------------------------------------------------------
    assign rs1_busy = (busy[rs1] || (reg_write && (write_reg == rs1))) && (rs1 != 5'd0);
    assign rs2_busy = (busy[rs2] || (reg_write && (write_reg == rs2))) && (rs2 != 5'd0);

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the busy vector is reset like any other control register;
            // unlike a data RAM, stale contents here would stall issue forever.
            busy         <= '0;
            reg_write    <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            conflict_cnt <= '0;
            last_grant   <= 1'b1;
        end else begin
            busy <= busy_next;

            // Writes to register 0 are accepted but never reach the file.
            reg_write <= acc_any && (acc_reg != 5'd0);

            // Address and data hold when nothing is accepted.
            if (acc_any) begin
                write_reg  <= acc_reg;
                write_data <= acc_data;
                last_grant <= acc1;
            end

            if (conflict && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Drives a round-robin instance and a fixed-priority instance from the same
// stimulus. Expected values come from a behavioural model of the writeback
// port and the register scoreboard kept in plain arrays.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wb0_valid, wb1_valid, rsv_valid;
    logic [4:0]  wb0_reg, wb1_reg, rsv_reg, rs1, rs2;
    logic [31:0] wb0_data, wb1_data;

    logic        wb0_ready, wb1_ready, rsv_ready, rs1_busy, rs2_busy, reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [15:0] conflict_cnt;

    logic        fp_wb0_ready, fp_wb1_ready, fp_rsv_ready, fp_rs1_busy, fp_rs2_busy, fp_reg_write;
    logic [4:0]  fp_write_reg;
    logic [31:0] fp_write_data;
    logic [15:0] fp_conflict_cnt;

    regfile_wb_arbiter #(.FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_ready(rsv_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.FAIR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(fp_wb0_ready),
        .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(fp_wb1_ready),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_ready(fp_rsv_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(fp_rs1_busy), .rs2_busy(fp_rs2_busy),
        .reg_write(fp_reg_write), .write_reg(fp_write_reg), .write_data(fp_write_data),
        .conflict_cnt(fp_conflict_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model (round-robin instance) -------------
    bit          m_busy [32];
    bit          m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    bit          m_wknown;   // write_reg/write_data are defined by the model
    int          m_last;
    int          m_cnt;

    // Winner index, or -1 when nobody is granted.
    function automatic int winner(bit v0, bit v1, bit fair);
        if (v0 && v1) return fair ? ((m_last == 0) ? 1 : 0) : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic bit exp_src_busy(logic [4:0] r);
        return (m_busy[r] || (m_we && m_wreg == r)) && (r != 5'd0);
    endfunction

    task automatic check_outputs();
        int g;
        int gf;
        g  = rst ? -1 : winner(wb0_valid, wb1_valid, 1'b1);
        gf = rst ? -1 : winner(wb0_valid, wb1_valid, 1'b0);
        check("wb0_ready", wb0_ready, g == 0);
        check("wb1_ready", wb1_ready, g == 1);
        check("fp_wb0_ready", fp_wb0_ready, gf == 0);
        check("fp_wb1_ready", fp_wb1_ready, gf == 1);
        check("rsv_ready", rsv_ready, !rst && (!m_busy[rsv_reg] || rsv_reg == 5'd0));
        check("rs1_busy", rs1_busy, exp_src_busy(rs1));
        check("rs2_busy", rs2_busy, exp_src_busy(rs2));
        check("reg_write", reg_write, m_we);
        if (m_wknown) begin
            check("write_reg", write_reg, m_wreg);
            check("write_data", write_data, m_wdata);
        end
        check("conflict_cnt", conflict_cnt, m_cnt);
        check("fp_conflict_cnt", fp_conflict_cnt, m_cnt);
    endtask

    task automatic model_edge();
        int g;
        bit rsv_ok;
        logic [4:0] r;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_we = 0; m_wreg = '0; m_wdata = '0; m_wknown = 1;
            m_last = 1; m_cnt = 0;
        end else begin
            g      = winner(wb0_valid, wb1_valid, 1'b1);
            rsv_ok = !m_busy[rsv_reg] || rsv_reg == 5'd0;
            m_we   = 0;
            if (g >= 0) begin
                r = (g == 1) ? wb1_reg : wb0_reg;
                m_busy[r] = 1'b0;
                m_last = g;
                if (r != 5'd0) begin
                    m_we = 1; m_wreg = r; m_wknown = 1;
                    m_wdata = (g == 1) ? wb1_data : wb0_data;
                end else begin
                    m_wknown = 0;
                end
            end
            if (rsv_valid && rsv_ok && rsv_reg != 5'd0) m_busy[rsv_reg] = 1'b1;
            if (wb0_valid && wb1_valid && m_cnt < 65535) m_cnt++;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; wb0_valid = 0; wb1_valid = 0; rsv_valid = 0;
    endtask

    task automatic do_reset(input int cycles);
        idle();
        rst = 1;
        repeat (cycles) step();
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        wb0_reg = 0; wb1_reg = 0; rsv_reg = 0; rs1 = 0; rs2 = 0;
        wb0_data = 0; wb1_data = 0;
        m_last = 1; m_cnt = 0; m_we = 0; m_wknown = 0;
        @(negedge clk);
        do_reset(2);

        // Reset state.
        #1;
        check("rst_reg_write", reg_write, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);

        // Single requester, one-cycle latency.
        wb1_valid = 1; wb1_reg = 5; wb1_data = 32'hDEADBEEF;
        #1 check("single_ready", wb1_ready, 1);
        step();
        idle();
        #1;
        check("single_we", reg_write, 1);
        check("single_reg", write_reg, 5);
        check("single_data", write_data, 32'hDEADBEEF);
        step();
        #1 check("single_we_off", reg_write, 0);
        check("hold_reg", write_reg, 5);
        step();

        // Conflicts right after reset.
        do_reset(1);
        wb0_valid = 1; wb1_valid = 1; wb0_reg = 10; wb1_reg = 11;
        for (int i = 0; i < 4; i++) begin
            wb0_data = 32'h100 + i; wb1_data = 32'h200 + i;
            #1;
            check("rr_grant1", wb1_ready, (i % 2) == 1);
            check("fp_grant1", fp_wb1_ready, 0);
            step();
        end
        idle();
        #1 check("rr_conflicts", conflict_cnt, 4);
        check("fp_conflicts", fp_conflict_cnt, 4);
        step();

        // Scoreboard: reserve 7, re-reserve refused, writeback, in-flight window.
        do_reset(1);
        rsv_valid = 1; rsv_reg = 7;
        step();
        rs1 = 7;
        #1 check("rsv7_busy", rs1_busy, 1);
        check("rsv7_again", rsv_ready, 0);
        step();
        idle();
        wb0_valid = 1; wb0_reg = 7; wb0_data = 32'h77;
        step();
        idle();
        #1 check("inflight7", rs1_busy, 1);
        step();
        #1 check("done7", rs1_busy, 0);
        step();

        // Same-edge reserve and writeback of unreserved 9: set wins.
        rsv_valid = 1; rsv_reg = 9; wb0_valid = 1; wb0_reg = 9; wb0_data = 32'h99;
        step();
        idle();
        step();
        rsv_valid = 1; rsv_reg = 9; rs1 = 9;
        #1 check("set_wins_busy", rs1_busy, 1);
        check("set_wins_rsv", rsv_ready, 0);
        step();
        idle();

        // Writeback to register 0 is consumed.
        wb1_valid = 1; wb1_reg = 0; wb1_data = 32'h1234;
        step();
        idle();
        #1 check("r0_no_write", reg_write, 0);
        step();

        // Reset mid-operation.
        do_reset(1);
        rsv_valid = 1; rsv_reg = 3;
        step();
        idle();
        wb0_valid = 1; wb1_valid = 1; wb0_reg = 12; wb1_reg = 13;
        wb0_data = 32'hAAAA; wb1_data = 32'hBBBB;
        repeat (10) step();
        idle();
        rs1 = 3;
        #1 check("pre_rst_cnt", conflict_cnt, 10);
        check("pre_rst_we", reg_write, 1);
        check("pre_rst_busy3", rs1_busy, 1);
        rst = 1; wb0_valid = 1; wb0_reg = 14; rsv_valid = 1; rsv_reg = 15;
        #1 check("rst_wb0_closed", wb0_ready, 0);
        check("rst_rsv_closed", rsv_ready, 0);
        step();
        idle();
        rs1 = 3; rs2 = 15;
        #1;
        check("post_rst_we", reg_write, 0);
        check("post_rst_reg", write_reg, 0);
        check("post_rst_data", write_data, 0);
        check("post_rst_cnt", conflict_cnt, 0);
        check("post_rst_busy3", rs1_busy, 0);
        check("post_rst_busy15", rs2_busy, 0);
        wb0_valid = 1; wb1_valid = 1;
        #1 check("post_rst_grant0", wb0_ready, 1);
        step();
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(99) == 0);
            wb0_valid = $urandom_range(1);
            wb1_valid = $urandom_range(1);
            rsv_valid = $urandom_range(1);
            wb0_reg   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            wb1_reg   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
            rsv_reg   = 5'($urandom_range(7));
            rs1       = 5'($urandom_range(7));
            rs2       = 5'($urandom);
            wb0_data  = $urandom;
            wb1_data  = $urandom;
            step();
        end
        idle();

        // Saturation of the conflict counter.
        do_reset(1);
        wb0_valid = 1; wb1_valid = 1; wb0_reg = 20; wb1_reg = 21;
        repeat (65540) step();
        #1 check("sat_cnt", conflict_cnt, 16'hFFFF);
        repeat (5) step();
        #1 check("sat_hold", conflict_cnt, 16'hFFFF);
        check("fp_sat_hold", fp_conflict_cnt, 16'hFFFF);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
